// File: rtl/lcp_imem_server.sv
// Instruction memory beside one LCP: RD_LAT-cycle pipelined 128-bit fetches plus a loader write port.
// Fetches never stall, and a fetch takes priority over a load in the same cycle.
module lcp_imem_server #(
  parameter int              ADDR_W      = 20,
  parameter int              DATA_W      = 128,
  parameter int              DEPTH       = 1024,
  parameter int              RD_LAT      = 1,
  parameter logic [7:0]      HALT_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_re,
  output logic [DATA_W-1:0] imem_data,
  output logic              imem_valid,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [31:0]       fetch_count,
  output logic              oob_err
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_A   = (ADDR_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0] HALT_WORD = {HALT_OPCODE, {(DATA_W-8){1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];

  logic              fetch_oob;
  logic              ld_oob;
  logic              ld_fire;
  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  ld_idx;

  logic [RD_LAT-1:0] vld_q,  vld_d;
  logic [DATA_W-1:0] word_q [RD_LAT];
  logic [DATA_W-1:0] word_d [RD_LAT];
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic              oob_err_q, oob_err_d;

  assign fetch_oob = {1'b0, imem_addr} >= DEPTH_A;
  assign ld_oob    = {1'b0, ld_addr} >= DEPTH_A;
  assign fetch_idx = imem_addr[IDX_W-1:0];
  assign ld_idx    = ld_addr[IDX_W-1:0];
  assign ld_ready  = ~imem_re;
  assign ld_fire   = ld_en & ld_ready;

  // Out-of-range loads are dropped; the aliased low index must not be written.
  always_ff @(posedge clk) begin
    if (ld_fire && !ld_oob) begin
      mem[ld_idx] <= ld_data;
    end
  end

  // Each stage's word only advances with a valid, so the last stage holds the previous reply.
  always_comb begin
    vld_d[0]  = imem_re;
    word_d[0] = word_q[0];
    if (imem_re) begin
      word_d[0] = fetch_oob ? HALT_WORD : mem[fetch_idx];
    end
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k]  = vld_q[k-1];
      word_d[k] = vld_q[k-1] ? word_q[k-1] : word_q[k];
    end
  end

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (imem_re && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    oob_err_d = oob_err_q | (imem_re & fetch_oob) | (ld_fire & ld_oob);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q         <= '0;
      fetch_count_q <= '0;
      oob_err_q     <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) begin
        word_q[k] <= '0;
      end
    end else begin
      vld_q         <= vld_d;
      fetch_count_q <= fetch_count_d;
      oob_err_q     <= oob_err_d;
      for (int k = 0; k < RD_LAT; k++) begin
        word_q[k] <= word_d[k];
      end
    end
  end

  assign imem_valid  = vld_q[RD_LAT-1];
  assign imem_data   = word_q[RD_LAT-1];
  assign fetch_count = fetch_count_q;
  assign oob_err     = oob_err_q;

endmodule

// File: tb/tb_lcp_imem_server.sv
// Directed bench: four instances (RD_LAT 1..4) share the same stimulus; each step checks
// the instance whose latency the step exercises.
module tb_lcp_imem_server;

  logic         clk;
  logic         rst;
  logic [19:0]  imem_addr;
  logic         imem_re;
  logic         ld_en;
  logic [19:0]  ld_addr;
  logic [127:0] ld_data;

  logic [127:0] data_w     [4];
  logic         valid_w    [4];
  logic         ld_ready_w [4];
  logic [31:0]  cnt_w      [4];
  logic         oob_w      [4];

  int checks;
  int errors;

  localparam logic [127:0] HALT = {8'hFF, 120'd0};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    lcp_imem_server #(.RD_LAT(g + 1)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_re     (imem_re),
      .imem_data   (data_w[g]),
      .imem_valid  (valid_w[g]),
      .ld_en       (ld_en),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready_w[g]),
      .fetch_count (cnt_w[g]),
      .oob_err     (oob_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    imem_addr = '0;
    imem_re   = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    tick();
    tick();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst_valid%0d", g), 128'(valid_w[g]), 128'd0);
      chk($sformatf("rst_data%0d", g), data_w[g], 128'd0);
      chk($sformatf("rst_cnt%0d", g), 128'(cnt_w[g]), 128'd0);
      chk($sformatf("rst_oob%0d", g), 128'(oob_w[g]), 128'd0);
    end
    rst = 1'b0;

    // 1: load HALT word at 0, fetch it with RD_LAT=1
    ld_en = 1'b1; ld_addr = 20'd0; ld_data = HALT;
    #1 chk("t1_ld_ready", 128'(ld_ready_w[0]), 128'd1);
    tick();
    ld_en = 1'b0;
    imem_re = 1'b1; imem_addr = 20'd0;
    tick();
    imem_re = 1'b0;
    chk("t1_valid", 128'(valid_w[0]), 128'd1);
    chk("t1_opcode", 128'(data_w[0][127:120]), 128'hFF);
    chk("t1_cnt", 128'(cnt_w[0]), 128'd1);
    tick();
    chk("t1_pulse", 128'(valid_w[0]), 128'd0);
    chk("t1_hold", data_w[0], HALT);

    // 2: load 0..7, back-to-back fetches, RD_LAT=3 reply stream
    for (int i = 0; i < 8; i++) begin
      ld_en = 1'b1; ld_addr = 20'(i); ld_data = 128'(i);
      tick();
    end
    ld_en = 1'b0;
    for (int k = 0; k < 11; k++) begin
      imem_re   = (k < 8);
      imem_addr = 20'(k);
      tick();
      chk($sformatf("t2_valid3_k%0d", k), 128'(valid_w[2]), 128'((k >= 2) && (k <= 9)));
      if ((k >= 2) && (k <= 9)) chk($sformatf("t2_data3_k%0d", k), data_w[2], 128'(k - 2));
      if (k < 8) chk($sformatf("t2_data1_k%0d", k), data_w[0], 128'(k));
    end
    chk("t2_cnt", 128'(cnt_w[2]), 128'd9);

    // 3: out-of-range fetch
    imem_re = 1'b1; imem_addr = 20'd1024;
    tick();
    imem_re = 1'b0;
    chk("t3_valid1", 128'(valid_w[0]), 128'd1);
    chk("t3_data1", data_w[0], HALT);
    chk("t3_oob", 128'(oob_w[0]), 128'd1);
    tick();
    tick();
    chk("t3_valid3", 128'(valid_w[2]), 128'd1);
    chk("t3_data3", data_w[2], HALT);
    chk("t3_oob_sticky", 128'(oob_w[0]), 128'd1);

    // 4: load/fetch conflict on address 3
    ld_en = 1'b1; ld_addr = 20'd3; ld_data = 128'hBEEF;
    imem_re = 1'b1; imem_addr = 20'd3;
    #1 chk("t4_ready_conflict", 128'(ld_ready_w[0]), 128'd0);
    tick();
    imem_re = 1'b0;
    chk("t4_old_data", data_w[0], 128'd3);
    #1 chk("t4_ready_free", 128'(ld_ready_w[0]), 128'd1);
    tick();
    ld_en = 1'b0;
    imem_re = 1'b1; imem_addr = 20'd3;
    tick();
    imem_re = 1'b0;
    chk("t4_new_data", data_w[0], 128'hBEEF);

    // 5: fetch then overwrite address 5, RD_LAT=2
    imem_re = 1'b1; imem_addr = 20'd5;
    tick();
    imem_re = 1'b0;
    ld_en = 1'b1; ld_addr = 20'd5; ld_data = 128'hB;
    tick();
    ld_en = 1'b0;
    chk("t5_valid_a", 128'(valid_w[1]), 128'd1);
    chk("t5_data_a", data_w[1], 128'd5);
    imem_re = 1'b1; imem_addr = 20'd5;
    tick();
    imem_re = 1'b0;
    chk("t5_gap", 128'(valid_w[1]), 128'd0);
    tick();
    chk("t5_valid_b", 128'(valid_w[1]), 128'd1);
    chk("t5_data_b", data_w[1], 128'hB);

    // 6: reset with three fetches in flight, RD_LAT=4
    for (int i = 0; i < 3; i++) begin
      imem_re = 1'b1; imem_addr = 20'(i);
      tick();
    end
    imem_re = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_data", data_w[3], 128'd0);
    chk("t6_cnt", 128'(cnt_w[3]), 128'd0);
    chk("t6_oob", 128'(oob_w[3]), 128'd0);
    chk("t6_valid", 128'(valid_w[3]), 128'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t6_no_valid_k%0d", k), 128'(valid_w[3]), 128'd0);
    end
    imem_re = 1'b1; imem_addr = 20'd3;
    tick();
    imem_re = 1'b0;
    tick();
    tick();
    chk("t6_early", 128'(valid_w[3]), 128'd0);
    tick();
    chk("t6_refetch_valid", 128'(valid_w[3]), 128'd1);
    chk("t6_refetch_data", data_w[3], 128'hBEEF);
    chk("t6_refetch_cnt", 128'(cnt_w[3]), 128'd1);

    // 7: out-of-range load is dropped and flags oob_err
    ld_en = 1'b1; ld_addr = 20'd1023; ld_data = 128'h77;
    tick();
    chk("t7_oob_clear", 128'(oob_w[0]), 128'd0);
    ld_addr = 20'hFFFFF; ld_data = 128'h1;
    tick();
    ld_en = 1'b0;
    chk("t7_oob_set", 128'(oob_w[0]), 128'd1);
    imem_re = 1'b1; imem_addr = 20'd1023;
    tick();
    imem_re = 1'b0;
    chk("t7_no_alias", data_w[0], 128'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
